cocochip_adc_frontend: RTL and testbench

COCOCHIP_ADC_FRONTEND -- requirements
Module: cocochip_adc_frontend

---
 rtl/cocochip_adc_frontend.sv | 148 ++++++++++++++
 tb/tb_cocochip_adc_frontend.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cocochip_adc_frontend.sv
// Serial ADC front end: runs framed conversions on one latched channel and
// reports the peak of the top 8 result bits once per window.
module cocochip_adc_frontend #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned SAMPLES = 64,
    parameter int unsigned GUARD   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] adc_channel_sel,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_din,
    input  logic       adc_dout,
    output logic [7:0] adc_data,
    output logic       adc_data_valid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GUARD,
        ST_DUMMY,
        ST_ACQ,
        ST_REPORT
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  div_cnt;
    logic [5:0]  half_cnt;
    logic [5:0]  half_nxt;
    logic [15:0] gcnt;
    logic [7:0]  smp_cnt;
    logic [1:0]  ch;
    logic [11:0] shreg;
    logic [7:0]  peak;
    logic [7:0]  peak_nxt;
    logic        in_frame;
    logic        half_end;
    logic        frame_end;
    logic        guard_done;
    logic        start_frame;

    // Frame timing decode: a frame is 34 half-periods of CLK_DIV cycles each.
    always_comb begin
        in_frame    = (state == ST_DUMMY) || (state == ST_ACQ);
        half_end    = in_frame && (div_cnt == 8'(CLK_DIV - 1));
        frame_end   = half_end && (half_cnt == 6'd33);
        half_nxt    = half_cnt + 6'd1;
        guard_done  = (gcnt == 16'(GUARD - 1));
        peak_nxt    = (shreg[11:4] > peak) ? shreg[11:4] : peak;
        start_frame = ((state_nxt == ST_DUMMY) || (state_nxt == ST_ACQ)) &&
                      (!in_frame || frame_end);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a running frame always completes before leaving.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (enable) state_nxt = ST_GUARD;
            ST_GUARD: begin
                if (!enable)                                  state_nxt = ST_IDLE;
                else if (guard_done && adc_channel_sel != 2'b11) state_nxt = ST_DUMMY;
            end
            ST_DUMMY: begin
                if (frame_end) state_nxt = enable ? ST_ACQ : ST_IDLE;
            end
            ST_ACQ: begin
                if (frame_end) begin
                    if (!enable)                          state_nxt = ST_IDLE;
                    else if (smp_cnt == 8'(SAMPLES - 1))  state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: state_nxt = enable ? ST_GUARD : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Guard counter, channel latch, sample counter and peak tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gcnt           <= '0;
            ch             <= '0;
            smp_cnt        <= '0;
            peak           <= '0;
            adc_data       <= '0;
            adc_data_valid <= 1'b0;
        end else begin
            gcnt <= (state == ST_GUARD && !guard_done) ? gcnt + 16'd1 : '0;
            if (state == ST_GUARD && state_nxt == ST_DUMMY) begin
                ch   <= adc_channel_sel;
                peak <= '0;
            end
            if (state != ST_ACQ)  smp_cnt <= '0;
            else if (frame_end)   smp_cnt <= smp_cnt + 8'd1;
            if (state == ST_ACQ && frame_end) peak <= peak_nxt;
            if (state == ST_ACQ && state_nxt == ST_REPORT) adc_data <= peak_nxt;
            adc_data_valid <= (state_nxt == ST_REPORT);
        end
    end

    // Serial pins are registered off the next half-period index so they
    // change exactly on the half-period boundary without decode glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
        end else if (start_frame) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
        end else if (half_end && !frame_end) begin
            div_cnt  <= '0;
            half_cnt <= half_nxt;
            adc_cs_n <= (half_nxt >= 6'd32);
            adc_sclk <= !(half_nxt[0] && half_nxt < 6'd32);
            if (half_nxt[0] && half_nxt < 6'd32) begin
                case (half_nxt[5:1])
                    5'd4:    adc_din <= ch[1];
                    5'd5:    adc_din <= ch[0];
                    default: adc_din <= 1'b0;
                endcase
            end
            if (!half_nxt[0] && half_nxt <= 6'd32) shreg <= {shreg[10:0], adc_dout};
        end else if (in_frame && !frame_end) begin
            div_cnt <= div_cnt + 8'd1;
        end else begin
            div_cnt  <= '0;
            half_cnt <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cocochip_adc_frontend.sv
// Directed bench for cocochip_adc_frontend with a behavioural serial ADC model.
module tb_cocochip_adc_frontend;

    localparam int CD = 2;
    localparam int NS = 4;
    localparam int GD = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       adc_dout = 1'b0;
    logic       adc_cs_n, adc_sclk, adc_din, adc_data_valid;
    logic [7:0] adc_data;

    int checks = 0;
    int failures = 0;

    cocochip_adc_frontend #(.CLK_DIV(CD), .SAMPLES(NS), .GUARD(GD)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .adc_channel_sel(sel),
        .adc_cs_n       (adc_cs_n),
        .adc_sclk       (adc_sclk),
        .adc_din        (adc_din),
        .adc_dout       (adc_dout),
        .adc_data       (adc_data),
        .adc_data_valid (adc_data_valid)
    );

    always #10 clk = ~clk;

    // ADC model: frame k (relative to fbase) returns resp[k]; top nibble of
    // the 16-bit word is junk that the DUT must ignore.
    logic [11:0] resp [0:31];
    int          fbase = 0;
    int          fidx = 0;
    int          falls = 0;
    int          rises = 0;
    logic [15:0] word = '0;
    logic [2:0]  addr_log [0:63];
    logic        cs_q = 1'b1;
    logic        sclk_q = 1'b1;
    int          vcount = 0;

    always @(adc_cs_n or adc_sclk) begin
        if (cs_q === 1'b1 && adc_cs_n === 1'b0 && reset_n === 1'b1) begin
            word  = {4'hF, ((fidx - fbase) >= 0 && (fidx - fbase) < 32) ? resp[fidx - fbase] : 12'h000};
            falls = 0;
            rises = 0;
            if (fidx < 64) addr_log[fidx] = 3'b111;
            fidx  = fidx + 1;
        end
        if (sclk_q === 1'b1 && adc_sclk === 1'b0 && adc_cs_n === 1'b0) begin
            if (falls < 16) adc_dout = word[15 - falls];
            falls = falls + 1;
        end
        if (sclk_q === 1'b0 && adc_sclk === 1'b1) begin
            if (rises >= 3 && rises <= 5 && fidx >= 1 && fidx <= 64)
                addr_log[fidx - 1][5 - rises] = adc_din;
            rises = rises + 1;
        end
        cs_q   = adc_cs_n;
        sclk_q = adc_sclk;
    end

    always @(posedge clk) if (adc_data_valid === 1'b1) vcount = vcount + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (adc_data_valid !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, adc_data_valid}, 32'd1);
    endtask

    task automatic set_resp(input logic [11:0] dummy, input logic [11:0] acq);
        resp[0] = dummy;
        for (int i = 1; i < 32; i++) resp[i] = acq;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cs_low;
        int vb;
        for (int i = 0; i < 32; i++) resp[i] = 12'h000;

        // Reset values
        repeat (3) tick();
        chk("rst_cs_n",  {31'd0, adc_cs_n}, 32'd1);
        chk("rst_sclk",  {31'd0, adc_sclk}, 32'd1);
        chk("rst_din",   {31'd0, adc_din}, 32'd0);
        chk("rst_valid", {31'd0, adc_data_valid}, 32'd0);
        chk("rst_data",  {24'd0, adc_data}, 32'h00);
        reset_n = 1'b1;
        repeat (2) tick();

        // Constant 0xA5C on channel 00: enable seen at tick 1, valid GD+5*68 later
        set_resp(12'hA5C, 12'hA5C);
        fbase = fidx;
        vb = vcount;
        sel = 2'b00;
        enable = 1'b1;
        wait_valid("A_valid", n);
        chk("A_latency", n, 1 + GD + (NS + 1) * 34 * CD);
        chk("A_data", {24'd0, adc_data}, 32'hA5);
        chk("A_frames", fidx - fbase, NS + 1);
        chk("A_addr0", {29'd0, addr_log[fbase]}, 32'd0);
        enable = 1'b0;
        tick();
        chk("A_pulse", {31'd0, adc_data_valid}, 32'd0);
        repeat (30) tick();
        chk("A_vcount", vcount - vb, 1);
        chk("A_hold", {24'd0, adc_data}, 32'hA5);
        chk("A_noframe", fidx - fbase, NS + 1);

        // Channel 10, dummy result must not contribute to the peak
        set_resp(12'hFFF, 12'h000);
        resp[1] = 12'h100; resp[2] = 12'hFF0; resp[3] = 12'h020; resp[4] = 12'h7FF;
        fbase = fidx;
        sel = 2'b10;
        enable = 1'b1;
        wait_valid("B1_valid", n);
        chk("B1_data", {24'd0, adc_data}, 32'hFF);
        chk("B1_addr0", {29'd0, addr_log[fbase]}, 32'b010);
        chk("B1_addr4", {29'd0, addr_log[fbase + 4]}, 32'b010);
        enable = 1'b0;
        repeat (10) tick();
        set_resp(12'hFFF, 12'h010);
        fbase = fidx;
        enable = 1'b1;
        wait_valid("B2_valid", n);
        chk("B2_data", {24'd0, adc_data}, 32'h01);
        enable = 1'b0;
        repeat (10) tick();

        // Reserved channel: no frames, no strobe
        fbase = fidx;
        vb = vcount;
        sel = 2'b11;
        enable = 1'b1;
        cs_low = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (adc_cs_n !== 1'b1) cs_low++;
        end
        chk("C_cs_low", cs_low, 0);
        chk("C_vcount", vcount - vb, 0);
        chk("C_frames", fidx - fbase, 0);
        enable = 1'b0;
        repeat (5) tick();

        // Channel change mid-window only affects the next window
        set_resp(12'h333, 12'h333);
        fbase = fidx;
        sel = 2'b00;
        enable = 1'b1;
        repeat (100) tick();
        sel = 2'b01;
        wait_valid("D1_valid", n);
        chk("D1_data", {24'd0, adc_data}, 32'h33);
        tick();
        set_resp(12'h333, 12'h333);
        wait_valid("D2_valid", n);
        enable = 1'b0;
        chk("D_addr_w1f0", {29'd0, addr_log[fbase]}, 32'b000);
        chk("D_addr_w1f4", {29'd0, addr_log[fbase + 4]}, 32'b000);
        chk("D_addr_w2f0", {29'd0, addr_log[fbase + 5]}, 32'b001);
        chk("D_addr_w2f4", {29'd0, addr_log[fbase + 9]}, 32'b001);
        repeat (10) tick();

        // Enable dropped in the 3rd ACQ frame: frame completes, no strobe
        set_resp(12'h123, 12'h123);
        fbase = fidx;
        vb = vcount;
        sel = 2'b00;
        enable = 1'b1;
        n = 0;
        while ((fidx - fbase) < 4 && n < 3000) begin
            tick();
            n++;
        end
        chk("E_reach_f3", fidx - fbase, 4);
        repeat (10) tick();
        chk("E_cs_low", {31'd0, adc_cs_n}, 32'd0);
        enable = 1'b0;
        n = 0;
        while (adc_cs_n !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        repeat (10) tick();
        chk("E_falls", falls, 16);
        chk("E_rises", rises, 16);
        chk("E_cs_n", {31'd0, adc_cs_n}, 32'd1);
        repeat (200) tick();
        chk("E_frames", fidx - fbase, 4);
        chk("E_vcount", vcount - vb, 0);
        chk("E_hold", {24'd0, adc_data}, 32'h33);

        // Asynchronous reset in the middle of a frame
        fbase = fidx;
        sel = 2'b01;
        enable = 1'b1;
        n = 0;
        while ((fidx - fbase) < 2 && n < 3000) begin
            tick();
            n++;
        end
        repeat (11) tick();
        chk("F_pre_cs", {31'd0, adc_cs_n}, 32'd0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("F_cs_n",  {31'd0, adc_cs_n}, 32'd1);
        chk("F_sclk",  {31'd0, adc_sclk}, 32'd1);
        chk("F_din",   {31'd0, adc_din}, 32'd0);
        chk("F_valid", {31'd0, adc_data_valid}, 32'd0);
        chk("F_data",  {24'd0, adc_data}, 32'h00);
        enable = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
